// File: rtl/pc_fetch_ctrl.sv
// Program counter owner and instruction fetch sequencer over a req/ack IMEM port.
// Latency: imem_ack in cycle N presents the instruction in the IF/ID slot in cycle N+1.
// Backpressure: stall holds the slot; one extra fetch lands in a skid entry, then requests pause.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [29:0] br_offset,
  input  logic        jmp,
  input  logic [25:0] jmp_index,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic [31:0] redir_pc4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  // One parked fetch result while the slot is blocked by stall.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } slot_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] fl_addr;   // address of the request being drained in FLUSH
  slot_t       skid;      // meaningful only while in S_HOLD

  logic        redir;
  logic        consume;
  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] redir_tgt;

  assign redir     = jr | jmp | br_taken;
  assign consume   = if_valid & ~stall;
  assign pc_plus4  = pc + 32'd4;
  assign br_tgt    = redir_pc4 + {br_offset, 2'b00};
  assign jmp_tgt   = {redir_pc4[31:28], jmp_index, 2'b00};
  assign jr_tgt    = {jr_addr[31:2], 2'b00};
  assign redir_tgt = jr ? jr_tgt : (jmp ? jmp_tgt : br_tgt);

  // A request stays up in FLUSH so the outstanding IMEM access can complete.
  assign imem_req  = (state == S_FETCH) || (state == S_FLUSH);
  assign imem_addr = (state == S_FLUSH) ? fl_addr : pc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: redirects win over stall; a pending request is never withdrawn.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (redir)                               state_nxt = imem_ack ? S_FETCH : S_FLUSH;
        else if (imem_ack && if_valid && !consume) state_nxt = S_HOLD;
      end
      S_HOLD:  if (redir || consume) state_nxt = S_FETCH;
      S_FLUSH: if (imem_ack)         state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // PC, output slot, skid entry and misalignment pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= RESET_PC;
      fl_addr      <= RESET_PC;
      skid         <= '0;
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= '0;
      if_pc4       <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= jr && (jr_addr[1:0] != 2'b00);
      if (redir) begin
        pc       <= redir_tgt;
        if_valid <= 1'b0;
        if (state == S_FETCH && !imem_ack) fl_addr <= pc;
      end else begin
        if (consume) if_valid <= 1'b0;
        case (state)
          S_FETCH: begin
            if (imem_ack) begin
              pc <= pc_plus4;
              if (!if_valid || consume) begin
                if_valid <= 1'b1;
                if_instr <= imem_rdata;
                if_pc    <= pc;
                if_pc4   <= pc_plus4;
              end else begin
                skid.instr <= imem_rdata;
                skid.pc    <= pc;
              end
            end
          end
          S_HOLD: begin
            if (consume) begin
              if_valid <= 1'b1;
              if_instr <= skid.instr;
              if_pc    <= skid.pc;
              if_pc4   <= skid.pc + 32'd4;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
